// File: rtl/mem_port_arbiter_if.sv
// Request/ready handshakes for fetch and load/store, plus the shared memory port.
// master = the arbiter, slave = the core/memory environment around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;
  logic          core_stall;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_req, mem_we, mem_addr, mem_wdata, err, core_stall
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_req, mem_we, mem_addr, mem_wdata, err, core_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and load/store with
// alternating tie-break, a one-cycle ready pulse per access and a watchdog abort.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic          owner_d_q, owner_d_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;
  logic          grant_d;
  logic          if_ready_c, d_ready_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      owner_d_q   <= 1'b0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      owner_d_q   <= owner_d_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    owner_d_d   = owner_d_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    // Data wins only when fetch is absent or fetch was granted last.
    grant_d     = bus.d_req && (!bus.if_req || !last_d_q);
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (bus.if_req || bus.d_req) begin
          state_d     = grant_d ? BUSY_D : BUSY_I;
          last_d_d    = grant_d;
          owner_d_d   = grant_d;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_d && bus.d_we;
          mem_addr_d  = grant_d ? bus.d_addr : bus.if_addr;
          mem_wdata_d = grant_d ? bus.d_wdata : '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (state_q == BUSY_D) d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          else                   if_rdata_d = bus.mem_rdata;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          err_d     = 1'b1;
          if (state_q == BUSY_D) d_rdata_d = '0;
          else                   if_rdata_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        wd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_ready_c     = (state_q == DONE) && !owner_d_q;
    d_ready_c      = (state_q == DONE) && owner_d_q;
    bus.if_ready   = if_ready_c;
    bus.d_ready    = d_ready_c;
    bus.if_rdata   = if_rdata_q;
    bus.d_rdata    = d_rdata_q;
    bus.mem_req    = mem_req_q;
    bus.mem_we     = mem_we_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    bus.err        = err_q;
    bus.core_stall = (bus.if_req && !if_ready_c) || (bus.d_req && !d_ready_c);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random fetch/load/store traffic against a behavioural memory; a scoreboard
// monitor checks every ready pulse, stall, hold and watchdog behaviour.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  exp_t iq[$];
  exp_t dq[$];
  bit   order_log[$];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  bit   spur_all = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic bit is_hang(input logic [31:0] a);
    return a[15:12] == 4'hF;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h00500093 : init_word(a);
  endfunction

  // Memory device: acks 0..2 cycles after mem_req rises, never acks hang
  // addresses (and then acks late once the request drops), random spurious acks.
  initial begin : responder
    bit in_acc = 0, hang_acc = 0;
    int lat = 0, cnt = 0;
    logic [31:0] s_addr, s_wdata;
    logic s_we;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_acc = 0;
        bus.mem_ack = 1'b0;
      end else if (!bus.mem_req) begin
        if (in_acc && hang_acc) begin
          check("hang_busy_cycles", cnt, TO);
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = $urandom;
        end else if (in_acc) begin
          check("ack_req_cycles", cnt, lat + 1);
          bus.mem_ack = 1'b0;
        end else begin
          bus.mem_ack   = spur_all || ($urandom_range(0, 5) == 0);
          bus.mem_rdata = $urandom;
        end
        in_acc = 0;
      end else begin
        if (!in_acc) begin
          in_acc   = 1;
          lat      = $urandom_range(0, 2);
          cnt      = 0;
          hang_acc = is_hang(bus.mem_addr);
          s_addr   = bus.mem_addr;
          s_we     = bus.mem_we;
          s_wdata  = bus.mem_wdata;
        end else begin
          check("mem_addr_stable", bus.mem_addr, s_addr);
          check("mem_we_stable", 32'(bus.mem_we), 32'(s_we));
          check("mem_wdata_stable", bus.mem_wdata, s_wdata);
        end
        cnt++;
        if (!hang_acc && cnt == lat + 1) begin
          bus.mem_ack = 1'b1;
          if (s_we) begin
            dev_mem[s_addr] = s_wdata;
            bus.mem_rdata   = $urandom;
          end else begin
            bus.mem_rdata = dev_mem.exists(s_addr) ? dev_mem[s_addr] : init_word(s_addr);
          end
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] last_if = '0, last_d = '0;
    int i_skips = 0, d_skips = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      check("core_stall", 32'(bus.core_stall),
            32'((bus.if_req && !bus.if_ready) || (bus.d_req && !bus.d_ready)));
      if (!reset) begin
        last_if = bus.if_rdata;
        last_d  = bus.d_rdata;
        i_skips = 0;
        d_skips = 0;
      end else begin
        if (bus.if_ready && bus.d_ready) check("both_ready", 32'd1, 32'd0);
        if (bus.err && !bus.if_ready && !bus.d_ready) check("err_without_ready", 32'd1, 32'd0);
        if (!bus.if_ready) check("if_rdata_hold", bus.if_rdata, last_if);
        if (!bus.d_ready)  check("d_rdata_hold", bus.d_rdata, last_d);
        if (bus.if_ready) begin
          order_log.push_back(1'b0);
          i_skips = 0;
          if (bus.d_req) begin
            d_skips++;
            check("d_wait_bound", 32'(d_skips > 1), 32'd0);
          end
          if (iq.size() == 0) check("if_unexpected_ready", 32'd1, 32'd0);
          else begin
            e = iq.pop_front();
            check("if_rdata", bus.if_rdata, e.data);
            check("if_err", 32'(bus.err), 32'(e.err));
          end
        end
        if (bus.d_ready) begin
          order_log.push_back(1'b1);
          d_skips = 0;
          if (bus.if_req) begin
            i_skips++;
            check("if_wait_bound", 32'(i_skips > 1), 32'd0);
          end
          if (dq.size() == 0) check("d_unexpected_ready", 32'd1, 32'd0);
          else begin
            e = dq.pop_front();
            check("d_rdata", bus.d_rdata, e.data);
            check("d_err", 32'(bus.err), 32'(e.err));
          end
        end
        last_if = bus.if_rdata;
        last_d  = bus.d_rdata;
      end
    end
  end

  task automatic wait_if();
    int n = 0;
    bit ok = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.if_ready) begin ok = 1; break; end
    end
    if (!ok) check("if_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_d();
    int n = 0;
    bit ok = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.d_ready) begin ok = 1; break; end
    end
    if (!ok) check("d_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic fetch_issue(input logic [31:0] a);
    exp_t e;
    e.err  = is_hang(a);
    e.data = is_hang(a) ? 32'h0 : fetch_word(a);
    iq.push_back(e);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
  endtask

  task automatic data_issue(input logic [31:0] a, input logic we, input logic [31:0] wd);
    exp_t e;
    e.err = is_hang(a);
    if (is_hang(a)) e.data = '0;
    else if (we) begin
      exp_mem[a] = wd;
      e.data = '0;
    end else e.data = exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    dq.push_back(e);
    bus.d_addr  = a;
    bus.d_we    = we;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
  endtask

  task automatic fetch_seq(input int n, input int maxidle);
    logic [31:0] a;
    repeat (n) begin
      repeat ($urandom_range(0, maxidle)) begin
        bus.if_req = 1'b0;
        @(posedge clk); #1;
      end
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'hF000;
      fetch_issue(a);
      wait_if();
    end
    bus.if_req = 1'b0;
  endtask

  task automatic data_seq(input int n, input int maxidle);
    logic [31:0] a;
    repeat (n) begin
      repeat ($urandom_range(0, maxidle)) begin
        bus.d_req   = 1'b0;
        bus.d_we    = 1'($urandom);
        bus.d_wdata = $urandom;
        @(posedge clk); #1;
      end
      a = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'hF800;
      data_issue(a, 1'($urandom), $urandom);
      wait_d();
    end
    bus.d_req = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [3:0] ord;
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    dev_mem[32'h40] = 32'h00500093;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_ready", 32'({bus.if_ready, bus.d_ready, bus.err}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Both held continuously from reset: fetch wins the first tie, then alternate.
    order_log.delete();
    fork
      fetch_seq(2, 0);
      data_seq(2, 0);
    join
    ord = '0;
    for (int i = 0; i < 4 && i < order_log.size(); i++) ord[i] = order_log[i];
    check("tie_order_IDID", 32'(ord), 32'b1010);
    check("tie_order_count", order_log.size(), 4);

    fetch_issue(32'h40);
    wait_if();
    bus.if_req = 1'b0;
    data_issue(32'h100, 1'b1, 32'hDEADBEEF);
    wait_d();
    data_issue(32'h100, 1'b0, 32'h0);
    wait_d();
    data_issue(32'hF810, 1'b0, 32'h0);
    wait_d();
    bus.d_req = 1'b0;

    fork
      fetch_seq(60, 2);
      data_seq(60, 2);
    join

    // Reset during a hung store; afterwards fetch must win the tie again.
    repeat (3) begin @(posedge clk); #1; end
    bus.d_addr = 32'hF804; bus.d_we = 1'b1; bus.d_wdata = 32'h12345678; bus.d_req = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_mem_bus", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_we), 32'd0);
    check("midrst_ready", 32'({bus.if_ready, bus.d_ready, bus.err}), 32'd0);
    check("midrst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
    bus.d_req = 1'b0;
    fetch_issue(32'h8);
    data_issue(32'h1004, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    order_log.delete();
    reset = 1'b1;
    fork
      begin wait_if(); bus.if_req = 1'b0; end
      begin wait_d();  bus.d_req  = 1'b0; end
    join
    check("post_reset_first_fetch", 32'(order_log.size() > 0 ? order_log[0] : 1'b1), 32'd0);

    // Acks with no request outstanding must be ignored.
    spur_all = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("spurious_no_activity", 32'({bus.mem_req, bus.if_ready, bus.d_ready}), 32'd0);
    end
    spur_all = 1'b0;

    repeat (3) @(posedge clk);
    check("if_queue_drained", iq.size(), 0);
    check("d_queue_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
